// File: rtl/math_pkg.sv
// rtl/math_pkg.sv - shared single-precision constants and field layout
package math_pkg;

   localparam int SINGLE_BIAS   = 127;
   localparam int SINGLE_FRAC_W = 23;
   localparam int SINGLE_EXP_W  = 8;

   typedef struct packed {
      logic                     sign;
      logic [SINGLE_EXP_W-1:0]  exp;
      logic [SINGLE_FRAC_W-1:0] frac;
   } single_t;

endpackage

// File: rtl/lzc32.sv
// rtl/lzc32.sv - combinational 32-bit leading-zero counter with all-zero flag
module lzc32 (
   input  logic [31:0] data,
   output logic [4:0]  count,
   output logic        zero
);

   // Scanning upward lets the highest set bit win the final assignment.
   always_comb begin
      count = 5'd0;
      zero  = 1'b1;
      for (int i = 0; i < 32; i++) begin
         if (data[i]) begin
            count = 5'(31 - i);
            zero  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/unsigned_int_to_single.sv
// rtl/unsigned_int_to_single.sv - 3-stage uint32 to single-precision converter, round-to-nearest-even
module unsigned_int_to_single
   import math_pkg::*;
#(
   parameter int BIAS = SINGLE_BIAS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready
);

   logic                     valid_1, valid_2;
   logic                     load_1, load_2, load_3;

   logic [31:0]              op_1;
   logic [4:0]               lz_1;
   logic                     zero_1;
   logic [4:0]               lz_c;
   logic                     zero_c;

   logic                     zero_2;
   logic [SINGLE_EXP_W-1:0]  exp_2;
   logic [SINGLE_FRAC_W-1:0] frac_2;

   logic [30:0]              norm;
   logic                     guard, sticky, round_up;
   logic [SINGLE_FRAC_W:0]   frac_r;
   logic [SINGLE_EXP_W-1:0]  exp_c;
   single_t                  packed_c;

   // Ready chain is combinational so a full pipe can enqueue and dequeue together.
   assign load_3   = !out_valid || out_ready;
   assign load_2   = !valid_2 || load_3;
   assign load_1   = !valid_1 || load_2;
   assign in_ready = load_1;

   lzc32 u_lzc (
      .data  (in_data),
      .count (lz_c),
      .zero  (zero_c)
   );

   // Normalise drops the implicit leading one; only bits below it are kept.
   always_comb begin
      norm     = 31'(op_1 << lz_1);
      guard    = norm[7];
      sticky   = |norm[6:0];
      round_up = guard && (sticky || norm[8]);
      frac_r   = {1'b0, norm[30:8]} + {{SINGLE_FRAC_W{1'b0}}, round_up};
      exp_c    = 8'(BIAS + 31) - {3'b000, lz_1} + {7'd0, frac_r[SINGLE_FRAC_W]};
   end

   always_comb begin
      packed_c.sign = 1'b0;
      packed_c.exp  = exp_2;
      packed_c.frac = frac_2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_1   <= 1'b0;
         valid_2   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 32'h0;
      end else begin
         if (load_1) valid_1 <= in_valid;
         if (load_2) valid_2 <= valid_1;
         if (load_3) begin
            out_valid <= valid_2;
            if (valid_2) out_data <= zero_2 ? 32'h0 : packed_c;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (load_1 && in_valid) begin
         op_1   <= in_data;
         lz_1   <= lz_c;
         zero_1 <= zero_c;
      end
      if (load_2 && valid_1) begin
         zero_2 <= zero_1;
         exp_2  <= exp_c;
         frac_2 <= frac_r[SINGLE_FRAC_W-1:0];
      end
   end

endmodule

// File: tb/tb_unsigned_int_to_single.sv
// tb/tb_unsigned_int_to_single.sv - randomized scoreboard bench for unsigned_int_to_single
module tb_unsigned_int_to_single;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [31:0] din;
      logic [31:0] exp;
      int          cyc;
      bit          lat;
      bit          rt;
   } item_t;

   item_t       sb[$];
   bit          front_seen = 0;
   bit          hold_valid = 0;
   logic [31:0] hold_data;
   bit          lat_check  = 0;
   bit          roundtrip  = 0;
   bit          rand_ready = 0;

   unsigned_int_to_single dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: pick the top bit, divide down, round the remainder against one half.
   function automatic logic [31:0] model(input logic [31:0] x);
      int     p;
      int     sh;
      longint q, r, half;
      if (x == 0) return 32'h0;
      p = 0;
      for (int i = 0; i < 32; i++) if (x[i]) p = i;
      if (p <= 23) begin
         q = longint'(x) * (longint'(1) << (23 - p));
      end else begin
         sh   = p - 23;
         q    = longint'(x) / (longint'(1) << sh);
         r    = longint'(x) - q * (longint'(1) << sh);
         half = longint'(1) << (sh - 1);
         if (r > half || (r == half && q % 2 == 1)) q = q + 1;
         if (q == (longint'(1) << 24)) begin
            q = longint'(1) << 23;
            p = p + 1;
         end
      end
      return {1'b0, 8'(127 + p), 23'(q % (longint'(1) << 23))};
   endfunction

   function automatic longint single_to_uint(input logic [31:0] f);
      int     e;
      longint m;
      if (f == 32'h0) return 0;
      e = int'(f[30:23]);
      m = longint'({1'b1, f[22:0]});
      if (e >= 150) return m * (longint'(1) << (e - 150));
      return m / (longint'(1) << (150 - e));
   endfunction

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         front_seen = 0;
         hold_valid = 0;
      end else begin
         if (hold_valid)
            chk(out_valid && out_data == hold_data, "hold_stable", out_data, hold_data);
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk(1'b0, "unexpected_out", out_data, 32'h0);
            end else begin
               if (!front_seen) begin
                  front_seen = 1;
                  if (sb[0].lat)
                     chk(cyc - sb[0].cyc == 3, "latency", 32'(cyc - sb[0].cyc), 32'd3);
               end
               if (out_ready) begin
                  chk(out_data == sb[0].exp, "result", out_data, sb[0].exp);
                  if (sb[0].rt)
                     chk(single_to_uint(out_data) == longint'(sb[0].din), "roundtrip",
                         32'(single_to_uint(out_data)), sb[0].din);
                  void'(sb.pop_front());
                  front_seen = 0;
               end
            end
         end
         hold_valid = out_valid && !out_ready;
         hold_data  = out_data;
         if (in_valid && in_ready)
            sb.push_back('{din: in_data, exp: model(in_data), cyc: cyc, lat: lat_check, rt: roundtrip});
      end
   end

   always @(posedge clk) begin
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic send(input logic [31:0] x);
      bit done = 0;
      in_data  = x;
      in_valid = 1'b1;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
      end
      if (!done) chk(1'b0, "send_timeout", x, x);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [31:0] basic_vals [8] = '{32'd0, 32'd1, 32'd100, 32'h80000000,
                                   32'd16777217, 32'd16777219, 32'd16777218, 32'hFFFFFFFF};
   logic [31:0] basic_exp  [8] = '{32'h00000000, 32'h3F800000, 32'h42C80000, 32'h4F000000,
                                   32'h4B800000, 32'h4B800002, 32'h4B800001, 32'h4F800000};

   initial begin
      int          idx;
      int          accepted;
      logic [31:0] bp_vals [10];

      rst       = 1'b1;
      in_data   = 32'h0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #1;
      chk(out_valid == 1'b0, "reset_out_valid", 32'(out_valid), 32'd0);
      chk(out_data == 32'h0, "reset_out_data", out_data, 32'h0);
      chk(in_ready == 1'b1, "reset_in_ready", 32'(in_ready), 32'd1);

      for (int i = 0; i < 8; i++)
         chk(model(basic_vals[i]) == basic_exp[i], "model_literal", model(basic_vals[i]), basic_exp[i]);

      idle(2);
      #2;
      rst = 1'b0;
      idle(1);

      lat_check = 1;
      for (int i = 0; i < 8; i++) send(basic_vals[i]);
      idle(5);

      for (int i = 0; i < 8; i++) begin
         send($urandom);
         @(negedge clk);
         chk(in_ready == 1'b1, "bubble_in_ready", 32'(in_ready), 32'd1);
         @(posedge clk);
         #1;
      end
      idle(5);

      lat_check = 0;
      for (int i = 0; i < 10; i++) bp_vals[i] = $urandom;
      idx      = 0;
      accepted = 0;
      for (int k = 1; k < 100 && idx < 10; k++) begin
         out_ready = !(k >= 2 && k <= 7);
         in_valid  = 1'b1;
         in_data   = bp_vals[idx];
         @(negedge clk);
         if (k == 7) begin
            chk(accepted == 3, "bp_accepted", 32'(accepted), 32'd3);
            chk(in_ready == 1'b0, "bp_in_ready", 32'(in_ready), 32'd0);
         end
         if (in_ready) begin
            idx++;
            if (k <= 7) accepted++;
         end
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk(idx == 10, "bp_all_sent", 32'(idx), 32'd10);
      idle(6);
      chk(sb.size() == 0, "bp_drained", 32'(sb.size()), 32'd0);

      send(32'd11);
      send(32'd22);
      send(32'd33);
      #3;
      rst = 1'b1;
      #1;
      chk(out_valid == 1'b0, "midrst_out_valid", 32'(out_valid), 32'd0);
      chk(out_data == 32'h0, "midrst_out_data", out_data, 32'h0);
      chk(in_ready == 1'b1, "midrst_in_ready", 32'(in_ready), 32'd1);
      idle(2);
      #2;
      rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk(out_valid == 1'b0, "postrst_idle", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;

      rand_ready = 1;
      roundtrip  = 1;
      for (int i = 0; i < 1000; i++) begin
         send($urandom_range(0, 32'h00FFFFFF));
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      roundtrip = 0;
      for (int i = 0; i < 300; i++) begin
         send($urandom);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      rand_ready = 0;
      #2;
      out_ready = 1'b1;
      for (int k = 0; k < 50 && sb.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      chk(sb.size() == 0, "final_drain", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
